// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder built from per-bit full-adder cells.
// sum, cout and ovf are captured one cycle after a valid operand set; out_valid marks fresh results.
module full_adder_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum_raw_c;
    logic             cout_raw_c;
    logic             carry_msb_c;

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             cout_d,  cout_q;
    logic             ovf_d,   ovf_q;
    logic             valid_d, valid_q;

    // Ripple carry chain; carry_msb_c ends up as the carry into the top cell.
    always_comb begin : carry_chain
        logic carry;
        carry       = cin;
        carry_msb_c = cin;
        sum_raw_c   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            carry_msb_c  = carry;
            sum_raw_c[i] = a[i] ^ b[i] ^ carry;
            carry        = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout_raw_c = carry;
    end

    // Capture only on valid input; otherwise hold results and drop the valid flag.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (in_valid) begin
            sum_d   = sum_raw_c;
            cout_d  = cout_raw_c;
            ovf_d   = carry_msb_c ^ cout_raw_c;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder_reg.sv
// Bench for full_adder_reg at WIDTH=1, 8 and 32: directed truth table, reset, hold and
// boundary steps, then random operands compared against an arithmetic reference model.
module tb_full_adder_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;

    logic        a1, b1, cin1, sum1, cout1, ovf1, ov1;
    logic [7:0]  a8, b8, sum8;
    logic        cin8, cout8, ovf8, ov8;
    logic [31:0] a32, b32, sum32;
    logic        cin32, cout32, ovf32, ov32;

    int n_assert;
    int n_fail;

    full_adder_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .out_valid(ov1)
    );

    full_adder_reg #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .out_valid(ov8)
    );

    full_adder_reg #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a32), .b(b32), .cin(cin32),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .out_valid(ov32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum at w+1 bits, overflow from signed range of a+b+cin.
    function automatic void ref_add(input int unsigned w, input longint unsigned ua,
                                    input longint unsigned ub, input bit c,
                                    output longint unsigned s, output bit co, output bit ov);
        longint unsigned total;
        longint          lim, sa, sb, ss;
        total = ua + ub + 64'(c);
        s     = total & ((64'd1 << w) - 64'd1);
        co    = ((total >> w) & 64'd1) != 64'd0;
        lim   = longint'(64'd1 << (w - 1));
        sa    = longint'(ua);
        sb    = longint'(ub);
        if (sa >= lim) sa = sa - 2 * lim;
        if (sb >= lim) sb = sb - 2 * lim;
        ss    = sa + sb + longint'(64'(c));
        ov    = (ss < -lim) || (ss >= lim);
    endfunction

    task automatic apply1(input logic va, input logic vb, input logic vc);
        @(negedge clk);
        in_valid = 1'b1;
        a1 = va; b1 = vb; cin1 = vc;
        @(posedge clk);
        #1;
    endtask

    task automatic apply8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        @(negedge clk);
        in_valid = 1'b1;
        a8 = va; b8 = vb; cin8 = vc;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] tt_in  [7];
    logic [1:0] tt_exp [7];
    logic [7:0] bd_a   [3];
    logic [7:0] bd_b   [3];
    logic       bd_c   [3];
    logic [9:0] bd_exp [3];

    initial begin
        longint unsigned ra [3];
        longint unsigned rb [3];
        bit              rc [3];
        longint unsigned es [3];
        bit              eco[3];
        bit              eov[3];
        longint unsigned ts;
        bit              tco, tov;
        int unsigned     wid [3];
        logic            v;

        n_assert = 0;
        n_fail   = 0;
        wid = '{1, 8, 32};
        tt_in  = '{3'b111, 3'b100, 3'b000, 3'b101, 3'b010, 3'b111, 3'b111};
        tt_exp = '{2'b11,  2'b01,  2'b00,  2'b10,  2'b01,  2'b11,  2'b11};
        bd_a   = '{8'hFF, 8'h7F, 8'hFF};
        bd_b   = '{8'h01, 8'h01, 8'hFF};
        bd_c   = '{1'b0,  1'b0,  1'b1};
        bd_exp = '{{8'h00, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b1}, {8'hFF, 1'b1, 1'b0}};

        rst_n = 1'b0; in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a32 = '0; b32 = '0; cin32 = 1'b0;

        // Reset held for 100 ns, then a valid operand while still in reset.
        #98;
        chk("rst_sum1", 64'(sum1), 64'd0);
        chk("rst_cout1", 64'(cout1), 64'd0);
        chk("rst_ovf8", 64'(ovf8), 64'd0);
        chk("rst_sum32", 64'(sum32), 64'd0);
        chk("rst_valid1", 64'(ov1), 64'd0);
        apply1(1'b1, 1'b1, 1'b1);
        chk("rst_edge_sum1", 64'(sum1), 64'd0);
        chk("rst_edge_valid1", 64'(ov1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_sum1", 64'(sum1), 64'd1);
        chk("rel_cout1", 64'(cout1), 64'd1);
        chk("rel_valid1", 64'(ov1), 64'd1);

        // WIDTH=1 truth table including back-to-back repeats of 1+1+1.
        for (int i = 0; i < 7; i++) begin
            tt_in[i][2:0] = tt_in[i];
            apply1(tt_in[i][2], tt_in[i][1], tt_in[i][0]);
            chk($sformatf("tt%0d_sum", i), 64'(sum1), 64'(tt_exp[i][0]));
            chk($sformatf("tt%0d_cout", i), 64'(cout1), 64'(tt_exp[i][1]));
            chk($sformatf("tt%0d_valid", i), 64'(ov1), 64'd1);
        end

        // Asynchronous reset asserted between edges clears outputs before the next edge.
        apply1(1'b1, 1'b1, 1'b1);
        chk("pre_async_valid", 64'(ov1), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_sum1", 64'(sum1), 64'd0);
        chk("async_cout1", 64'(cout1), 64'd0);
        chk("async_ovf1", 64'(ovf1), 64'd0);
        chk("async_valid1", 64'(ov1), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Hold: results persist and out_valid drops when in_valid is low, even with X inputs.
        apply1(1'b0, 1'b1, 1'b0);
        chk("hold_pre_sum", 64'(sum1), 64'd1);
        chk("hold_pre_valid", 64'(ov1), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_sum", 64'(sum1), 64'd1);
        chk("hold_cout", 64'(cout1), 64'd0);
        chk("hold_valid", 64'(ov1), 64'd0);
        @(negedge clk);
        a1 = 1'bx; b1 = 1'bx; cin1 = 1'bx;
        @(posedge clk);
        #1;
        chk("hold_x_sum", 64'(sum1), 64'd1);
        chk("hold_x_cout", 64'(cout1), 64'd0);

        // WIDTH=8 carry/overflow boundaries.
        for (int i = 0; i < 3; i++) begin
            apply8(bd_a[i], bd_b[i], bd_c[i]);
            chk($sformatf("bd%0d_sum", i), 64'(sum8), 64'(bd_exp[i][9:2]));
            chk($sformatf("bd%0d_cout", i), 64'(cout8), 64'(bd_exp[i][1]));
            chk($sformatf("bd%0d_ovf", i), 64'(ovf8), 64'(bd_exp[i][0]));
        end

        // Random operands on all widths; idle cycles drive X and expect held results.
        for (int n = 0; n < 10000; n++) begin
            v = (n == 0) || ($urandom_range(0, 9) != 0);
            ra[0] = 64'($urandom_range(0, 1));
            ra[1] = 64'($urandom_range(0, 255));
            ra[2] = 64'($urandom);
            rb[0] = 64'($urandom_range(0, 1));
            rb[1] = 64'($urandom_range(0, 255));
            rb[2] = 64'($urandom);
            for (int k = 0; k < 3; k++) rc[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
            in_valid = v;
            if (v) begin
                a1 = 1'(ra[0]);  b1 = 1'(rb[0]);  cin1 = rc[0];
                a8 = 8'(ra[1]);  b8 = 8'(rb[1]);  cin8 = rc[1];
                a32 = 32'(ra[2]); b32 = 32'(rb[2]); cin32 = rc[2];
                for (int k = 0; k < 3; k++) begin
                    ref_add(wid[k], ra[k], rb[k], rc[k], ts, tco, tov);
                    es[k] = ts; eco[k] = tco; eov[k] = tov;
                end
            end else begin
                a1 = 'x; b1 = 'x; cin1 = 'x;
                a8 = 'x; b8 = 'x; cin8 = 'x;
                a32 = 'x; b32 = 'x; cin32 = 'x;
            end
            @(posedge clk);
            #1;
            chk("rnd_w1_sum", 64'(sum1), es[0]);
            chk("rnd_w1_cout", 64'(cout1), 64'(eco[0]));
            chk("rnd_w1_ovf", 64'(ovf1), 64'(eov[0]));
            chk("rnd_w1_valid", 64'(ov1), 64'(v));
            chk("rnd_w8_sum", 64'(sum8), es[1]);
            chk("rnd_w8_cout", 64'(cout8), 64'(eco[1]));
            chk("rnd_w8_ovf", 64'(ovf8), 64'(eov[1]));
            chk("rnd_w8_valid", 64'(ov8), 64'(v));
            chk("rnd_w32_sum", 64'(sum32), es[2]);
            chk("rnd_w32_cout", 64'(cout32), 64'(eco[2]));
            chk("rnd_w32_ovf", 64'(ovf32), 64'(eov[2]));
            chk("rnd_w32_valid", 64'(ov32), 64'(v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
